tcs3200_scan_ctrl: RTL

Scan controller for the TCS3200 colour sensor path. It drives the sensor filter-select lines through a green/red/blue measurement sequence. In each window it counts rising edges of the sensor frequency output, picks the strongest channel, and offers the result to the UART transmit path over a valid/ready handshake. It sits between the sensor pins and the UART framer and supports single-shot and free-running scans.

---
 rtl/tcs3200_scan_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tcs3200_scan_ctrl.sv
// TCS3200 colour scan controller.
// Steps the S2/S3 filter select through green, red and blue windows, counts
// synchronised rising edges of the sensor output in each window, picks the
// strongest channel and offers the result over a valid/ready handshake.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, filter parked on clear
// MEAS_G | green window: settle blanking, then count edges
// MEAS_R | red window
// MEAS_B | blue window
// DECIDE | one cycle: choose winner, load colour and result registers
// REPORT | result offered until meas_ready; then rescan or go idle
module tcs3200_scan_ctrl #(
    parameter int WIN_CYCLES    = 500,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk_1MHz,
    input  logic             reset,
    input  logic             cs_out,
    input  logic             start,
    input  logic             continuous,
    output logic [1:0]       filter,
    output logic [1:0]       color,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [1:0]       meas_color,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_sat
);

    localparam int PHASES = SETTLE_CYCLES + WIN_CYCLES;
    localparam int PH_W   = $clog2(PHASES + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]  PH_OPEN = PH_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_MAX - CNT_W'(1);

    typedef enum logic [2:0] {IDLE, MEAS_G, MEAS_R, MEAS_B, DECIDE, REPORT} state_t;

    state_t           state, state_nxt;
    logic             cs_s1, cs_s2, cs_prev;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic             scan_sat;
    logic             in_meas, count_en, hit_top;
    logic [CNT_W-1:0] cnt_sel;
    logic [1:0]       win_color;
    logic [CNT_W-1:0] win_count;

    // State register
    always_ff @(posedge clk_1MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and handshake/status outputs
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        meas_valid = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = MEAS_G;
            MEAS_G: if (phase == PH_LAST) state_nxt = MEAS_R;
            MEAS_R: if (phase == PH_LAST) state_nxt = MEAS_B;
            MEAS_B: if (phase == PH_LAST) state_nxt = DECIDE;
            DECIDE: state_nxt = REPORT;
            REPORT: begin
                meas_valid = 1'b1;
                if (meas_ready) state_nxt = continuous ? MEAS_G : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge qualification for the channel currently being measured
    always_comb begin
        in_meas = (state == MEAS_G) || (state == MEAS_R) || (state == MEAS_B);
        case (state)
            MEAS_G:  cnt_sel = cnt_g;
            MEAS_R:  cnt_sel = cnt_r;
            default: cnt_sel = cnt_b;
        endcase
        count_en = in_meas && cs_s2 && !cs_prev && (phase >= PH_OPEN);
        hit_top  = count_en && (cnt_sel >= CNT_TOP);
    end

    // Winner: largest count, ties go red, then green, then blue
    always_comb begin
        win_color = 2'd0;
        win_count = '0;
        if (cnt_r == '0 && cnt_g == '0 && cnt_b == '0) begin
            win_color = 2'd0;
        end else if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
            win_color = 2'd1;
            win_count = cnt_r;
        end else if (cnt_g >= cnt_b) begin
            win_color = 2'd2;
            win_count = cnt_g;
        end else begin
            win_color = 2'd3;
            win_count = cnt_b;
        end
    end

    // Synchroniser, phase timer, channel counters and result registers
    always_ff @(posedge clk_1MHz) begin
        if (reset) begin
            cs_s1      <= 1'b0;
            cs_s2      <= 1'b0;
            cs_prev    <= 1'b0;
            phase      <= '0;
            cnt_r      <= '0;
            cnt_g      <= '0;
            cnt_b      <= '0;
            scan_sat   <= 1'b0;
            filter     <= 2'd2;
            color      <= 2'd0;
            meas_color <= 2'd0;
            meas_count <= '0;
            meas_sat   <= 1'b0;
        end else begin
            cs_s1   <= cs_out;
            cs_s2   <= cs_s1;
            cs_prev <= cs_s2;

            if (in_meas) phase <= phase + PH_W'(1);

            // Counter holds at its maximum; reaching it marks the scan saturated
            if (count_en && cnt_sel != CNT_MAX) begin
                case (state)
                    MEAS_G:  cnt_g <= cnt_g + CNT_W'(1);
                    MEAS_R:  cnt_r <= cnt_r + CNT_W'(1);
                    default: cnt_b <= cnt_b + CNT_W'(1);
                endcase
            end
            if (hit_top) scan_sat <= 1'b1;

            if (state == DECIDE) begin
                color      <= win_color;
                meas_color <= win_color;
                meas_count <= win_count;
                meas_sat   <= scan_sat;
            end

            // Entry actions: filter select is registered with the state change
            if (state_nxt != state) begin
                phase <= '0;
                case (state_nxt)
                    MEAS_G: begin
                        filter   <= 2'd3;
                        cnt_g    <= '0;
                        scan_sat <= 1'b0;
                    end
                    MEAS_R: begin
                        filter <= 2'd0;
                        cnt_r  <= '0;
                    end
                    MEAS_B: begin
                        filter <= 2'd1;
                        cnt_b  <= '0;
                    end
                    default: filter <= 2'd2;
                endcase
            end
        end
    end

endmodule
